counter_cmd_arbiter: RTL and testbench

- Shares one WIDTH-bit counter register among NREQ requesters.
- Each requester issues a command (clear, load, increment, decrement) over a valid/ready handshake.
- A round-robin arbiter grants one command at a time; a 3-state FSM executes it and returns the updated count with the requester ID.
- Sits between software-visible command sources and the shared count register; it is the sole writer of that register.

---
 rtl/counter_cmd_arbiter.sv | 125 ++++++++++++
 tb/tb_counter_cmd_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_arbiter.sv
// Shared WIDTH-bit counter written by NREQ requesters through a round-robin arbiter.
// Each accepted command takes three cycles: grant/capture, execute, respond.
module counter_cmd_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 4,
   localparam int IDW  = $clog2(NREQ)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [2*NREQ-1:0]       req_op,
   input  logic [WIDTH*NREQ-1:0]   req_data,
   output logic [NREQ-1:0]         req_ready,
   output logic [WIDTH-1:0]        count,
   output logic                    rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [WIDTH-1:0]        rsp_count,
   output logic                    rsp_wrap,
   output logic                    busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;
   typedef enum logic [1:0] {OP_CLEAR = 2'b00, OP_LOAD = 2'b01, OP_INC = 2'b10, OP_DEC = 2'b11} op_e;

   state_e           state, state_nx;
   logic [IDW-1:0]   rr_ptr, winner, cap_id;
   logic             found;
   op_e              cap_op;
   logic [WIDTH-1:0] cap_data, count_nx;
   logic             wrap_nx;
   logic [1:0]       op_arr   [NREQ];
   logic [WIDTH-1:0] data_arr [NREQ];

   always_comb begin : unpack
      for (int i = 0; i < NREQ; i++) begin
         op_arr[i]   = req_op[2*i +: 2];
         data_arr[i] = req_data[WIDTH*i +: WIDTH];
      end
   end

   // Scan upward from rr_ptr, wrapping at NREQ (which need not be a power of two).
   always_comb begin : pick
      logic [IDW:0] sum;
      logic [IDW-1:0] idx;
      // NOTE: every combinational output gets a default first so no path can infer a latch.
      winner = '0;
      found  = 1'b0;
      sum    = '0;
      idx    = '0;
      for (int i = 0; i < NREQ; i++) begin
         sum = {1'b0, rr_ptr} + (IDW+1)'(i);
         if (sum >= (IDW+1)'(NREQ))
            sum = sum - (IDW+1)'(NREQ);
         idx = sum[IDW-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   assign req_ready = (state == S_IDLE && found) ? (NREQ'(1) << winner) : '0;
   assign busy      = (state != S_IDLE);
   assign rsp_valid = (state == S_RESP);

   always_comb begin : execute
      count_nx = count;
      wrap_nx  = 1'b0;
      unique case (cap_op)
         OP_CLEAR: count_nx = '0;
         OP_LOAD:  count_nx = cap_data;
         OP_INC: begin
            count_nx = count + WIDTH'(1);
            wrap_nx  = (count == '1);
         end
         OP_DEC: begin
            count_nx = count - WIDTH'(1);
            wrap_nx  = (count == '0);
         end
      endcase
   end

   always_comb begin : fsm_next
      state_nx = state;
      unique case (state)
         S_IDLE: if (found) state_nx = S_EXEC;
         S_EXEC: state_nx = S_RESP;
         S_RESP: state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         count     <= '0;
         rr_ptr    <= '0;
         cap_id    <= '0;
         cap_op    <= OP_CLEAR;
         cap_data  <= '0;
         rsp_id    <= '0;
         rsp_count <= '0;
         rsp_wrap  <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            S_IDLE: if (found) begin
               cap_id   <= winner;
               cap_op   <= op_e'(op_arr[winner]);
               cap_data <= data_arr[winner];
            end
            S_EXEC: begin
               count     <= count_nx;
               rsp_id    <= cap_id;
               rsp_count <= count_nx;
               rsp_wrap  <= wrap_nx;
            end
            S_RESP: rr_ptr <= (cap_id == IDW'(NREQ-1)) ? '0 : cap_id + IDW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_counter_cmd_arbiter.sv
// Self-checking bench for counter_cmd_arbiter: directed plan steps followed by
// randomized traffic, all compared against a behavioural model of the counter and pointer.
module tb_counter_cmd_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 4;
   localparam logic [1:0] CLR = 2'd0, LD = 2'd1, INC = 2'd2, DEC = 2'd3;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [2*NREQ-1:0]     req_op;
   logic [WIDTH*NREQ-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [WIDTH-1:0]      count;
   logic                  rsp_valid;
   logic [1:0]            rsp_id;
   logic [WIDTH-1:0]      rsp_count;
   logic                  rsp_wrap;
   logic                  busy;

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   // Behavioural model state
   int         m_count = 0;
   int         m_ptr = 0;
   logic [3:0] vmask = '0;
   logic [1:0] ops   [NREQ];
   logic [3:0] datas [NREQ];
   int         last_w;
   int         grant_cyc [$];

   counter_cmd_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_data(req_data),
      .req_ready(req_ready), .count(count), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
      .rsp_count(rsp_count), .rsp_wrap(rsp_wrap), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cycle++;
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_op[2*i +: 2]   = ops[i];
         req_data[4*i +: 4] = datas[i];
      end
      req_valid = vmask;
   endtask

   function automatic int model_winner();
      for (int k = 0; k < NREQ; k++)
         if (vmask[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
      return -1;
   endfunction

   // One full command: grant in this cycle, response two cycles later, back in IDLE.
   task automatic issue();
      int w, e, wr;
      drive();
      #1;
      w = model_winner();
      check("grant", req_ready, 32'(1) << w);
      check("busy_idle", busy, 0);
      grant_cyc.push_back(cycle);
      wr = 0;
      case (ops[w])
         CLR: e = 0;
         LD:  e = int'(datas[w]);
         INC: begin e = (m_count + 1) % 16; wr = (m_count == 15); end
         default: begin e = (m_count + 15) % 16; wr = (m_count == 0); end
      endcase
      tick();
      check("exec_ready", req_ready, 0);
      check("exec_busy", busy, 1);
      check("exec_rsp_valid", rsp_valid, 0);
      tick();
      check("resp_valid", rsp_valid, 1);
      check("resp_id", rsp_id, w);
      check("resp_count", rsp_count, e);
      check("resp_wrap", rsp_wrap, wr);
      check("resp_count_reg", count, e);
      check("resp_ready", req_ready, 0);
      check("resp_busy", busy, 1);
      m_count = e;
      m_ptr   = (w + 1) % NREQ;
      last_w  = w;
      tick();
      check("post_rsp_valid", rsp_valid, 0);
      check("post_rsp_hold", rsp_count, e);
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin ops[i] = CLR; datas[i] = '0; end
      drive();

      // Reset and idle
      for (int c = 0; c < 2; c++) begin
         tick();
         check("rst_count", count, 0);
         check("rst_rsp_valid", rsp_valid, 0);
         check("rst_ready", req_ready, 0);
         check("rst_busy", busy, 0);
      end
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("idle_count", count, 0);
         check("idle_rsp_valid", rsp_valid, 0);
         check("idle_ready", req_ready, 0);
         check("idle_busy", busy, 0);
         check("idle_rsp_id", rsp_id, 0);
      end

      // Single LOAD 9 from requester 1
      vmask = 4'b0010; ops[1] = LD; datas[1] = 4'd9;
      issue();
      check("single_id", rsp_id, 1);
      check("single_count", count, 9);
      vmask = '0;

      // Bring count to 0 and pointer to 0 via req 2 then req 3
      vmask = 4'b0100; ops[2] = CLR; issue(); vmask = '0;
      vmask = 4'b1000; ops[3] = CLR; issue(); vmask = '0;

      // Round-robin with all four holding INC
      for (int i = 0; i < NREQ; i++) ops[i] = INC;
      vmask = 4'b1111;
      grant_cyc.delete();
      for (int k = 0; k < 5; k++) begin
         issue();
         check("rr_order", rsp_id, k % 4);
         check("rr_count", rsp_count, k + 1);
      end
      for (int k = 1; k < 5; k++)
         check("rr_spacing", grant_cyc[k] - grant_cyc[k-1], 3);
      vmask = '0;

      // Pointer skip: rr_ptr=1, only req 3 and req 0 valid
      ops[3] = INC; ops[0] = DEC;
      vmask = 4'b1001;
      issue();
      check("skip_first", rsp_id, 3);
      vmask = 4'b0001;
      issue();
      check("skip_second", rsp_id, 0);
      vmask = '0;

      // Wrap behaviour
      vmask = 4'b0010; ops[1] = LD; datas[1] = 4'd15; issue(); vmask = '0;
      vmask = 4'b0100; ops[2] = INC; issue(); vmask = '0;
      check("wrap_inc_count", rsp_count, 0);
      check("wrap_inc_flag", rsp_wrap, 1);
      vmask = 4'b1000; ops[3] = DEC; issue(); vmask = '0;
      check("wrap_dec_count", rsp_count, 15);
      check("wrap_dec_flag", rsp_wrap, 1);
      vmask = 4'b0001; ops[0] = CLR; issue(); vmask = '0;
      check("clear_count", rsp_count, 0);
      check("clear_flag", rsp_wrap, 0);

      // Reset during EXEC of LOAD 7 from requester 2 (rr_ptr is 1 here)
      vmask = 4'b0100; ops[2] = LD; datas[2] = 4'd7;
      drive();
      #1;
      check("rstmid_grant", req_ready, 4'b0100);
      tick();
      check("rstmid_exec_busy", busy, 1);
      rst = 1'b1; vmask = '0; drive();
      tick();
      check("rstmid_rsp_valid", rsp_valid, 0);
      check("rstmid_count", count, 0);
      check("rstmid_busy", busy, 0);
      rst = 1'b0;
      tick();
      check("rstmid_rsp_valid2", rsp_valid, 0);
      check("rstmid_count2", count, 0);
      m_count = 0; m_ptr = 0;
      for (int i = 0; i < NREQ; i++) ops[i] = INC;
      vmask = 4'b1111;
      issue();
      check("rstmid_next_id", rsp_id, 0);
      check("rstmid_next_count", count, 1);
      vmask = '0;

      // Randomized traffic against the model
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!vmask[i] && $urandom_range(0, 1) == 1) begin
               vmask[i] = 1'b1;
               ops[i]   = 2'($urandom_range(0, 3));
               datas[i] = 4'($urandom_range(0, 15));
            end else if (vmask[i] && $urandom_range(0, 7) == 0) begin
               vmask[i] = 1'b0;
            end
         end
         if (vmask == '0 || $urandom_range(0, 5) == 0) begin
            logic [3:0] save;
            save = vmask;
            vmask = '0;
            drive();
            #1;
            check("rand_idle_ready", req_ready, 0);
            check("rand_idle_busy", busy, 0);
            tick();
            check("rand_idle_rsp", rsp_valid, 0);
            vmask = save;
            if (vmask == '0) begin
               vmask[$urandom_range(0, 3)] = 1'b1;
            end
         end
         issue();
         vmask[last_w] = 1'b0;
      end

      vmask = '0;
      drive();
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
